// File: rtl/fwd_pkg.sv
// Shared types and forwarding-select helper for the forwarding/hazard unit.
package fwd_pkg;

  typedef logic [2:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 3'b001;
  localparam fwd_sel_t FWD_EXMEM = 3'b010;
  localparam fwd_sel_t FWD_MEMWB = 3'b100;

  // Register indices are zero-extended to this width so one helper serves any REG_AW.
  localparam int FWD_IDX_W = 16;
  typedef logic [FWD_IDX_W-1:0] fwd_idx_t;

  function automatic fwd_sel_t fwd_select(
    input fwd_idx_t src,
    input fwd_idx_t exmem_rd,
    input logic     exmem_we,
    input fwd_idx_t memwb_rd,
    input logic     memwb_we,
    input logic     hz
  );
    fwd_sel_t sel;
    logic     src_zero;
    src_zero = hz && (src == '0);
    sel      = FWD_RF;
    if (exmem_we && (exmem_rd == src) && !src_zero) begin
      sel = FWD_EXMEM;
    end else if (memwb_we && (memwb_rd == src) && !src_zero) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_load_scoreboard.sv
// Per-register load countdown scoreboard; reports whether either ID source is still
// waiting on an in-flight load.
module load_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int REG_AW         = $clog2(NUM_REGS),
  parameter int LOAD_LAT       = 1,
  parameter int HARDWIRED_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              busy_rs,
  output logic              busy_rt
);

  localparam int CW    = $clog2(LOAD_LAT + 1);
  localparam int IDX_N = 1 << REG_AW;
  localparam logic [CW-1:0] LAT_V = CW'(LOAD_LAT);

  logic [CW-1:0]       cnt [NUM_REGS];
  logic [NUM_REGS-1:0] hit;
  logic [IDX_N-1:0]    nz;

  always_comb begin
    hit = '0;
    nz  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      hit[r] = issue && id_reg_write && (id_rd == REG_AW'(r)) &&
               !((HARDWIRED_ZERO != 0) && (r == 0));
      nz[r]  = (cnt[r] != '0);
    end
  end

  // An issuing writer overrides the countdown: loads arm it, ALU writes clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (hit[r]) begin
          cnt[r] <= id_is_load ? LAT_V : '0;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  assign busy_rs = nz[id_rs] && !((HARDWIRED_ZERO != 0) && (id_rs == '0));
  assign busy_rt = nz[id_rt] && !((HARDWIRED_ZERO != 0) && (id_rt == '0));

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use stall generation.
// Optional performance counters (stall_cnt, fwd_cnt) enabled by FWD_HAZARD_PERF_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int REG_AW         = $clog2(NUM_REGS),
  parameter int LOAD_LAT       = 1,
  parameter int HARDWIRED_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  output logic [2:0]        fwd_a,
  output logic [2:0]        fwd_b,
  output logic              stall
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  localparam logic HZ = (HARDWIRED_ZERO != 0);

  logic busy_rs;
  logic busy_rt;
  logic issue;

  assign stall = id_valid && ((id_use_rs && busy_rs) || (id_use_rt && busy_rt));
  assign issue = id_valid && !stall;

  load_scoreboard #(
    .NUM_REGS      (NUM_REGS),
    .REG_AW        (REG_AW),
    .LOAD_LAT      (LOAD_LAT),
    .HARDWIRED_ZERO(HARDWIRED_ZERO)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue),
    .id_rd       (id_rd),
    .id_reg_write(id_reg_write),
    .id_is_load  (id_is_load),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .busy_rs     (busy_rs),
    .busy_rt     (busy_rt)
  );

  assign fwd_a = fwd_select(FWD_IDX_W'(ex_rs), FWD_IDX_W'(exmem_rd), exmem_reg_write,
                            FWD_IDX_W'(memwb_rd), memwb_reg_write, HZ);
  assign fwd_b = fwd_select(FWD_IDX_W'(ex_rt), FWD_IDX_W'(exmem_rd), exmem_reg_write,
                            FWD_IDX_W'(memwb_rd), memwb_reg_write, HZ);

`ifdef FWD_HAZARD_PERF_EN
  // Saturating event counters; they hold at all-ones rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (((fwd_a != FWD_RF) || (fwd_b != FWD_RF)) && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load;
  logic [4:0] id_rs, id_rt, id_rd, ex_rs, ex_rt, exmem_rd, memwb_rd;
  logic exmem_reg_write, memwb_reg_write;
  logic [2:0] fa1, fb1, fa3, fb3;
  logic st1, st3;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit #(.LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .memwb_rd(memwb_rd),
    .memwb_reg_write(memwb_reg_write), .fwd_a(fa1), .fwd_b(fb1), .stall(st1)
`ifdef FWD_HAZARD_PERF_EN
    , .stall_cnt(sc1), .fwd_cnt(fc1)
`endif
  );

  fwd_hazard_unit #(.LOAD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .memwb_rd(memwb_rd),
    .memwb_reg_write(memwb_reg_write), .fwd_a(fa3), .fwd_b(fb3), .stall(st3)
`ifdef FWD_HAZARD_PERF_EN
    , .stall_cnt(sc3), .fwd_cnt(fc3)
`endif
  );

  typedef struct {
    logic [2:0] fa;
    logic [2:0] fb;
    logic       s1;
    logic       s3;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int m[2][32];
  int ps[2];
  int pf;
  int checks = 0;
  int errors = 0;
  int n1, n3;

  function automatic logic [2:0] mfwd(input logic [4:0] src);
    if (src != 5'd0 && exmem_reg_write && exmem_rd == src) return 3'b010;
    if (src != 5'd0 && memwb_reg_write && memwb_rd == src) return 3'b100;
    return 3'b001;
  endfunction

  function automatic logic mstall(input int k);
    return id_valid && ((id_use_rs && id_rs != 5'd0 && m[k][id_rs] != 0) ||
                        (id_use_rt && id_rt != 5'd0 && m[k][id_rt] != 0));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      ps[k] = 0;
      for (int r = 0; r < 32; r++) m[k][r] = 0;
    end
    pf = 0;
  endtask

  // Advance one rising edge, updating the reference model with the inputs held across it.
  task automatic tick();
    bit s, iss;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (mfwd(ex_rs) != 3'b001 || mfwd(ex_rt) != 3'b001) pf++;
      for (int k = 0; k < 2; k++) begin
        s   = mstall(k);
        iss = id_valid && !s;
        if (s) ps[k]++;
        for (int r = 1; r < 32; r++) begin
          if (iss && id_reg_write && id_rd == 5'(r)) m[k][r] = id_is_load ? (k == 1 ? 3 : 1) : 0;
          else if (m[k][r] > 0) m[k][r]--;
        end
      end
    end
    #1;
  endtask

  task automatic push_exp();
    q.push_back('{mfwd(ex_rs), mfwd(ex_rt), mstall(0), mstall(1)});
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                        input logic wr, input logic ld);
    id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_rd = rd; id_reg_write = wr; id_is_load = ld;
  endtask

  task automatic clr_inputs();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_rs = 0; ex_rt = 0; exmem_rd = 0; memwb_rd = 0;
    exmem_reg_write = 0; memwb_reg_write = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_inputs();
    model_clear();
    tick();
    push_exp();
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if ({fa1, fb1, fa3, fb3, st1, st3} !== {3'b001, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0} ||
        e.fa !== 3'b001) begin
      errors++;
      $display("FAIL reset: fa1=%b fb1=%b fa3=%b fb3=%b st1=%b st3=%b want 001/001 stall 0",
               fa1, fb1, fa3, fb3, st1, st3);
    end
    rst = 1'b0;
  endtask

  task automatic test_fwd_priority();
    for (int i = 0; i < 6; i++) begin
      tick();
      clr_inputs();
      case (i)
        0: begin ex_rs = 5; exmem_rd = 5; memwb_rd = 5; exmem_reg_write = 1; memwb_reg_write = 1; end
        1: begin ex_rs = 5; exmem_rd = 5; memwb_rd = 5; memwb_reg_write = 1; end
        2: begin ex_rs = 0; exmem_rd = 0; exmem_reg_write = 1; end
        3: begin ex_rt = 0; memwb_rd = 0; memwb_reg_write = 1; end
        4: begin ex_rs = 3; ex_rt = 6; exmem_rd = 6; exmem_reg_write = 1; memwb_rd = 3; memwb_reg_write = 1; end
        default: begin ex_rs = 4; ex_rt = 4; exmem_rd = 2; memwb_rd = 1; exmem_reg_write = 1; memwb_reg_write = 1; end
      endcase
      push_exp();
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({fa1, fb1, fa3, fb3} !== {e.fa, e.fb, e.fa, e.fb}) begin
        errors++;
        $display("FAIL fwd[%0d]: fa1=%b fb1=%b fa3=%b fb3=%b want fa=%b fb=%b",
                 i, fa1, fb1, fa3, fb3, e.fa, e.fb);
      end
    end
    checks++;
    if (fa1 !== 3'b001 || fb1 !== 3'b001) begin
      errors++;
      $display("FAIL fwd_nomatch: fa=%b fb=%b want 001/001", fa1, fb1);
    end
  endtask

  // Run a load to rd followed by a held reader; counts stall cycles per instance.
  task automatic run_load_reader(input string name, input logic [4:0] rd,
                                 input logic [4:0] rs, input logic urs,
                                 input logic [4:0] rt, input logic urt,
                                 input bit alu_between, input int hold);
    n1 = 0; n3 = 0;
    for (int i = 0; i < hold + 2; i++) begin
      tick();
      clr_inputs();
      if (i == 0) set_id(1, 0, 0, 0, 0, rd, 1, 1);
      else if (i == 1 && alu_between) set_id(1, 0, 0, 0, 0, rd, 1, 0);
      else if (i <= hold) set_id(1, rs, urs, rt, urt, 0, 0, 0);
      push_exp();
      @(negedge clk);
      e = q.pop_front();
      n1 += int'(st1);
      n3 += int'(st3);
      checks++;
      if ({st1, st3} !== {e.s1, e.s3}) begin
        errors++;
        $display("FAIL %s[%0d]: st1=%b st3=%b want st1=%b st3=%b", name, i, st1, st3, e.s1, e.s3);
      end
    end
  endtask

  task automatic test_load_use();
    run_load_reader("load_use", 7, 7, 1, 0, 0, 0, 5);
    checks++;
    if (n1 !== 1 || n3 !== 3) begin
      errors++;
      $display("FAIL load_use_len: n1=%0d n3=%0d want 1 and 3", n1, n3);
    end
    run_load_reader("unused_src", 7, 7, 0, 7, 0, 0, 4);
    checks++;
    if (n1 !== 0 || n3 !== 0) begin
      errors++;
      $display("FAIL unused_src_len: n1=%0d n3=%0d want 0 and 0", n1, n3);
    end
  endtask

  task automatic test_alu_clear_and_zero();
    run_load_reader("alu_clear", 9, 0, 0, 9, 1, 1, 4);
    checks++;
    if (n1 !== 0 || n3 !== 0) begin
      errors++;
      $display("FAIL alu_clear_len: n1=%0d n3=%0d want 0 and 0", n1, n3);
    end
    run_load_reader("zero_reg", 0, 0, 1, 0, 1, 0, 4);
    checks++;
    if (n1 !== 0 || n3 !== 0) begin
      errors++;
      $display("FAIL zero_reg_len: n1=%0d n3=%0d want 0 and 0", n1, n3);
    end
  endtask

  task automatic test_reset_mid_stall();
    tick();
    set_id(1, 0, 0, 0, 0, 12, 1, 1);
    tick();
    set_id(1, 0, 0, 12, 1, 0, 0, 0);
    push_exp();
    @(negedge clk);
    e = q.pop_front();
    checks++;
    if ({st1, st3} !== {e.s1, e.s3} || st3 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_stall: st1=%b st3=%b want st1=%b st3=1", st1, st3, e.s1);
    end
    #1 rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (st1 !== 1'b0 || st3 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_stall: st1=%b st3=%b want 0 0", st1, st3);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      tick();
      set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 1'($urandom),
             5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom_range(0, 2) == 0));
      ex_rs = 5'($urandom_range(0, 7)); ex_rt = 5'($urandom_range(0, 7));
      exmem_rd = 5'($urandom_range(0, 7)); memwb_rd = 5'($urandom_range(0, 7));
      exmem_reg_write = 1'($urandom); memwb_reg_write = 1'($urandom);
      push_exp();
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({fa1, fb1, fa3, fb3, st1, st3} !== {e.fa, e.fb, e.fa, e.fb, e.s1, e.s3}) begin
        errors++;
        $display("FAIL random[%0d]: fa=%b fb=%b st1=%b st3=%b want fa=%b fb=%b st1=%b st3=%b",
                 i, fa1, fb1, st1, st3, e.fa, e.fb, e.s1, e.s3);
      end
    end
    clr_inputs();
  endtask

`ifdef FWD_HAZARD_PERF_EN
  task automatic test_perf();
    tick();
    rst = 1'b1;
    clr_inputs();
    tick();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ex_rs = 5; exmem_rd = 5; exmem_reg_write = 1;
    end
    tick();
    clr_inputs();
    @(negedge clk);
    checks++;
    if (fc1 !== 32'd6 || fc3 !== 32'd6 || sc1 !== 32'd0 || sc3 !== 32'd0) begin
      errors++;
      $display("FAIL perf_fwd: fc1=%0d fc3=%0d sc1=%0d sc3=%0d want 6 6 0 0", fc1, fc3, sc1, sc3);
    end
    run_load_reader("perf_stall", 7, 7, 1, 0, 0, 0, 5);
    run_load_reader("perf_stall2", 8, 0, 0, 8, 1, 0, 2);
    checks++;
    if (sc1 !== 32'(ps[0]) || sc3 !== 32'(ps[1]) || fc1 !== 32'(pf) || sc1 !== 32'd2 || sc3 !== 32'd5) begin
      errors++;
      $display("FAIL perf_stall_cnt: sc1=%0d sc3=%0d fc1=%0d want %0d %0d %0d", sc1, sc3, fc1, ps[0], ps[1], pf);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (sc1 !== 32'd0 || sc3 !== 32'd0 || fc1 !== 32'd0 || fc3 !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: sc1=%0d sc3=%0d fc1=%0d fc3=%0d want 0", sc1, sc3, fc1, fc3);
    end
    model_clear();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_alu_clear_and_zero();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef FWD_HAZARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor of the 5-stage pipeline forwarding unit.
- Adds a per-register load scoreboard that generates load-use stalls for configurable load latency.
- Gives EX/MEM forwarding priority over MEM/WB and suppresses forwarding/stalls on the hardwired zero register.
- Sits beside the ID/EX pipeline register: forward selects drive the EX-stage operand muxes; stall freezes PC and IF/ID and bubbles ID/EX.

Parameters:
- NUM_REGS, 32, architectural register count.
- REG_AW, $clog2(NUM_REGS), register-index width.
- LOAD_LAT, 1, cycles a dependent must stall after a load issues (1 = classic single-cycle load-use bubble; >1 for multi-cycle memory stages).
- HARDWIRED_ZERO, 1, when 1, register index 0 never forwards, never stalls, never enters the scoreboard.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  instruction in ID is valid.
- id_rs  in  REG_AW  ID source A index.
- id_rt  in  REG_AW  ID source B index.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_rd  in  REG_AW  ID destination index.
- id_reg_write  in  1  ID instruction writes a register.
- id_is_load  in  1  ID instruction is a load.
- ex_rs  in  REG_AW  ID/EX source A index.
- ex_rt  in  REG_AW  ID/EX source B index.
- exmem_rd  in  REG_AW  EX/MEM destination index.
- exmem_reg_write  in  1  EX/MEM write enable.
- memwb_rd  in  REG_AW  MEM/WB destination index.
- memwb_reg_write  in  1  MEM/WB write enable.
- fwd_a  out  3  one-hot operand A select: 001 regfile, 010 EX/MEM, 100 MEM/WB.
- fwd_b  out  3  one-hot operand B select, same encoding.
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Reset: all scoreboard counters go to 0, giving stall=0. fwd_a/fwd_b=001 whenever no match (combinational).
- Forwarding (combinational, zero latency), per operand:
  - 010 if exmem_reg_write and exmem_rd==source and not (HARDWIRED_ZERO and source==0).
  - Otherwise 100 if the same conditions hold on the MEM/WB inputs.
  - Otherwise 001.
  - EX/MEM strictly wins when both stages match.
- Scoreboard: cnt[r] is $clog2(LOAD_LAT+1) bits for each register r.
- Issue is the rising edge at which id_valid=1 and stall=0.
- On issue:
  - If id_reg_write and id_is_load (and rd nonzero when HARDWIRED_ZERO), then cnt[id_rd] <= LOAD_LAT.
  - If id_reg_write and not a load, then cnt[id_rd] <= 0, because the newer producer is covered by normal forwarding.
- Every other nonzero counter decrements by 1 each cycle. It saturates at 0, with no wrap.
- Set/clear on issue overrides the decrement for the same register in the same cycle.
- Re-issuing a load to an already pending rd reloads the counter to LOAD_LAT.
- stall (combinational from state plus ID inputs) = id_valid and ((id_use_rs and cnt[id_rs]!=0) or (id_use_rt and cnt[id_rt]!=0)), with index 0 excluded when HARDWIRED_ZERO.
- While stalled there is no issue, so the scoreboard only decrements. Stall lasts exactly the remaining count.
- An unused source (id_use_*=0) never stalls.
- id_valid=0: stall=0 and no scoreboard update beyond decrement.
- Reset asserted mid-stall: counters clear immediately (asynchronously) and stall drops in the same cycle.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined:
  - Adds output stall_cnt [31:0], counting cycles with stall=1. Reset to 0; saturates at 32'hFFFF_FFFF.
  - Adds output fwd_cnt [31:0], counting cycles where fwd_a!=001 or fwd_b!=001. Same reset and saturation.
- When undefined: neither port nor its logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package fwd_pkg holds:
  - typedef fwd_sel_t (3-bit one-hot);
  - constants FWD_RF=3'b001, FWD_EXMEM=3'b010, FWD_MEMWB=3'b100;
  - function fwd_select(src, exmem_rd, exmem_we, memwb_rd, memwb_we, hz) returning fwd_sel_t.
- One sub-module: load_scoreboard, containing the counter array, the update logic and the per-source busy lookup. The top instantiates it and computes stall and forwarding.

Test Plan:
- Reset, all inputs 0 -> fwd_a=fwd_b=001, stall=0. Assert rst for one cycle mid-run -> stall drops the same cycle.
- exmem_rd=memwb_rd=5, both write enables 1, ex_rs=5 -> fwd_a=010. Drop exmem_reg_write -> fwd_a=100.
- ex_rs=0, exmem_rd=0, exmem_reg_write=1, HARDWIRED_ZERO=1 -> fwd_a=001.
- LOAD_LAT=1: issue load rd=7, then next cycle id_rs=7 with id_use_rs=1 -> stall=1 for exactly 1 cycle. Repeat with id_use_rs=0 -> no stall.
- LOAD_LAT=3: load rd=9, then dependent on rt=9 -> stall high 3 consecutive cycles, then low. Load rd=9 followed by an ALU write rd=9 -> counter cleared, later reader of r9 does not stall.
- FWD_HAZARD_PERF_EN: 4 stall cycles and 6 forwarding cycles -> stall_cnt=4, fwd_cnt=6. Both return to 0 on rst.
